// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module  : sub_bytes_engine
// Brief   : AES SubBytes on a 128-bit state, LANES S-box lookups per cycle.
//           Define SUB_BYTES_SHIFT_ROWS_EN to fuse ShiftRows onto the output.
// Revision: 1.0
// ============================================================================
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int c_groups = 16 / LANES;
  localparam int c_cw     = (c_groups > 1) ? $clog2(c_groups) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_groups - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_process = 2'd1;
  localparam logic [1:0] c_done    = 2'd2;

  localparam logic [7:0] c_sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_cnt;
  logic [127:0]    r_work;
  logic [127:0]    r_out;
  logic            r_out_valid;

  logic [3:0]      w_idx    [LANES];
  logic [6:0]      w_base   [LANES];
  logic [7:0]      w_sb_in  [LANES];
  logic [7:0]      w_sb_out [LANES];
  logic [127:0]    w_work_next;
  logic [127:0]    w_out_next;

  // Byte i lives at bit offset 8*(15-i); for a 4-bit index that is {~i, 3'b000}.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_idx[l]    = 4'((int'(r_cnt) * LANES + l) % 16);
    assign w_base[l]   = {~w_idx[l], 3'b000};
    assign w_sb_in[l]  = r_work[w_base[l] +: 8];
    assign w_sb_out[l] = c_sbox[w_sb_in[l]];
  end

  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_next[w_base[l] +: 8] = w_sb_out[l];
    end
  end

`ifdef SUB_BYTES_SHIFT_ROWS_EN
  always_comb begin
    w_out_next = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_out_next[8*(15 - (r + 4*c)) +: 8] = w_work_next[8*(15 - (r + 4*((c + r) % 4))) +: 8];
      end
    end
  end
`else
  assign w_out_next = w_work_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_cnt       <= '0;
      r_work      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_work  <= in_state;
            r_cnt   <= '0;
            r_state <= c_process;
          end
        end
        c_process: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + c_one;
          // The final group's result goes straight to the output register.
          if (r_cnt == c_last) begin
            r_out       <= w_out_next;
            r_out_valid <= 1'b1;
            r_state     <= c_done;
          end
        end
        c_done: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_idle) && !rst;
  assign busy      = (r_state != c_idle);
  assign out_valid = r_out_valid;
  assign out_state = r_out;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_bytes_engine
// Brief   : Bench for sub_bytes_engine, one instance per legal LANES value.
// Revision: 1.0
// ============================================================================
module tb_sub_bytes_engine;

  localparam int N = 5;
  localparam logic [127:0] c_vec_a = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef SUB_BYTES_SHIFT_ROWS_EN
  localparam logic [127:0] c_exp_a = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] c_exp_a = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0]   in_state;
  logic [127:0]   out_state [N];

  for (genvar k = 0; k < N; k++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << k)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .in_state (in_state),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .out_state(out_state[k]),
      .busy     (busy[k])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'({b, b} >> (8 - n));
  endfunction

  task automatic build_tbl();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_fn(input logic [127:0] s);
    logic [7:0]   w [16];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) w[i] = tbl[8'(s >> (8 * (15 - i)))];
    for (int i = 0; i < 16; i++) begin
`ifdef SUB_BYTES_SHIFT_ROWS_EN
      o = {o[119:0], w[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]};
`else
      o = {o[119:0], w[i]};
`endif
    end
    return o;
  endfunction

  // Transaction-level model: accept, wait 16/LANES edges, hold until handshake.
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_valid = '0;
  int           m_edges [N];
  logic [127:0] m_res   [N];
  logic [127:0] m_last  [N];
  initial for (int k = 0; k < N; k++) begin m_edges[k] = 0; m_res[k] = '0; m_last[k] = '0; end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_pend[k] <= 1'b0; m_valid[k] <= 1'b0; m_edges[k] <= 0; m_last[k] <= '0;
      end else if (m_valid[k]) begin
        if (out_ready[k]) begin m_valid[k] <= 1'b0; m_pend[k] <= 1'b0; end
      end else if (m_pend[k]) begin
        m_edges[k] <= m_edges[k] + 1;
        if (m_edges[k] + 1 == (16 >> k)) begin m_valid[k] <= 1'b1; m_last[k] <= m_res[k]; end
      end else if (in_valid[k]) begin
        m_pend[k] <= 1'b1; m_edges[k] <= 0; m_res[k] <= model_fn(in_state);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("L%0d out_valid", 1 << k), 128'(out_valid[k]), 128'(m_valid[k]));
      check($sformatf("L%0d in_ready", 1 << k), 128'(in_ready[k]), 128'(!m_pend[k] && !rst));
      check($sformatf("L%0d busy", 1 << k), 128'(busy[k]), 128'(m_pend[k]));
      check($sformatf("L%0d out_state", 1 << k), out_state[k], m_last[k]);
    end
  end

  task automatic send(input int k, input logic [127:0] d, output int acc);
    int n;
    n = 0;
    while (!in_ready[k] && n < 100) begin @(negedge clk); n++; end
    if (!in_ready[k]) check("send timeout", 128'(in_ready[k]), 128'(1));
    in_valid[k] = 1'b1;
    in_state    = d;
    @(posedge clk); #1 acc = cyc;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 40) begin
      @(posedge clk); #1;
      if (out_valid[k]) begin at = cyc; break; end
      n++;
    end
    if (at < 0) check("wait out_valid timeout", 128'(out_valid[k]), 128'(1));
  endtask

  task automatic run(input int k, input logic [127:0] d, input logic [127:0] exp, input string nm);
    int acc, at;
    send(k, d, acc);
    wait_valid(k, at);
    check({nm, " latency"}, 128'(at - acc), 128'(16 >> k));
    check({nm, " result"}, out_state[k], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, at;
    logic [127:0] held;
    rst = 1'b1; in_valid = '0; out_ready = '1; in_state = '0;
    build_tbl();
    check("sbox 00", 128'(tbl[8'h00]), 128'h63);
    check("sbox 52", 128'(tbl[8'h52]), 128'h00);
    check("sbox ff", 128'(tbl[8'hff]), 128'h16);
    check("sbox 53", 128'(tbl[8'h53]), 128'hed);
    check("model vector", model_fn(c_vec_a), c_exp_a);

    repeat (2) @(negedge clk);
    check("reset out_valid", 128'(out_valid[2]), 128'(0));
    check("reset in_ready", 128'(in_ready[2]), 128'(0));
    check("reset busy", 128'(busy[2]), 128'(0));
    check("reset out_state", out_state[2], 128'(0));

    rst = 1'b0; #1;
    run(2, c_vec_a, c_exp_a, "vector");
    run(2, {16{8'h00}}, {16{8'h63}}, "all00");
    run(2, {16{8'h52}}, {16{8'h00}}, "all52");
    run(2, {16{8'hff}}, {16{8'h16}}, "allff");

    // Backpressure: hold the result for 10 cycles.
    repeat (2) @(negedge clk);
    out_ready[2] = 1'b0;
    send(2, c_vec_a, acc);
    wait_valid(2, at);
    held = out_state[2];
    check("bp result", held, c_exp_a);
    repeat (10) begin
      @(negedge clk);
      check("bp out_valid held", 128'(out_valid[2]), 128'(1));
      check("bp out_state held", out_state[2], c_exp_a);
    end
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    check("bp after handshake out_valid", 128'(out_valid[2]), 128'(0));
    check("bp after handshake in_ready", 128'(in_ready[2]), 128'(1));

    // A second offer while processing must be ignored.
    @(negedge clk);
    send(2, c_vec_a, acc);
    in_valid[2] = 1'b1; in_state = {16{8'h52}};
    repeat (2) @(negedge clk);
    in_valid[2] = 1'b0;
    wait_valid(2, at);
    check("busy-input latency", 128'(at - acc), 128'(4));
    check("busy-input result", out_state[2], c_exp_a);

    // Reset after two processing edges.
    repeat (2) @(negedge clk);
    send(2, {16{8'hff}}, acc);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    check("midrst out_valid", 128'(out_valid[2]), 128'(0));
    check("midrst busy", 128'(busy[2]), 128'(0));
    check("midrst in_ready", 128'(in_ready[2]), 128'(0));
    check("midrst out_state", out_state[2], 128'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    run(2, {16{8'h00}}, {16{8'h63}}, "post-reset");

    // Sweep every LANES value with the reference vector.
    for (int k = 0; k < N; k++) begin
      repeat (2) @(negedge clk);
      run(k, c_vec_a, c_exp_a, $sformatf("sweep L%0d", 1 << k));
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: number of Sbox instances, i.e. bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a new state.
REQ-007 SHALL have port in_state, input, 128 bits: AES state; byte i is bits [127-8i : 120-8i], at row i%4 and column i/4.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-010 SHALL have port out_state, output, 128 bits: the substituted state, using the same byte mapping as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, PROCESS and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE with rst low.
  - An input is accepted on a rising edge where in_valid and in_ready are both 1.
  - On acceptance, SHALL capture in_state into the work register, clear the group counter and go to PROCESS.
REQ-014 In PROCESS, SHALL on each edge replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the work register with their AES S-box values, in place, and then increment cnt.
REQ-015 SHALL go from PROCESS to DONE on the edge that processes group 16/LANES-1.
  - The counter is log2(16/LANES) bits wide (minimum 1) and is not used past the last group.
REQ-016 SHALL assert out_valid exactly 16/LANES rising edges after the accepting edge (4 edges for LANES=4, 16 for LANES=1, 1 for LANES=16).
REQ-017 In DONE, SHALL hold out_valid = 1 and keep out_state stable until out_ready = 1.
  - On the edge with out_valid and out_ready both 1, SHALL go to IDLE and clear out_valid.
REQ-018 SHALL ignore in_valid outside IDLE; in_state SHALL NOT be sampled there.
REQ-019 SHALL NOT allow back-to-back overlap: the next acceptance happens at the earliest one edge after the output handshake (minimum period 16/LANES+2 cycles).
REQ-020 SHALL keep out_state unchanged outside DONE; the work register SHALL be separate from, or only copied to, out_state on entry to DONE.
REQ-021 SHALL use the standard FIPS-197 S-box, combinational, identical to the team's existing Sbox table, with LANES instances.

Reset
REQ-022 While rst is high, SHALL asynchronously force:
  - FSM = IDLE, counter = 0, work register = 0;
  - out_state = 0, out_valid = 0, busy = 0, in_ready = 0.
REQ-023 rst asserted in PROCESS or DONE SHALL abort the operation; the partial result is discarded and never presented.
REQ-024 On the first edge after rst deasserts, in_ready SHALL be 1 and the block SHALL accept an input on that edge if in_valid = 1.

Configuration
REQ-025 Macro SUB_BYTES_SHIFT_ROWS_EN SHALL control a fused ShiftRows on the output.
  - Defined: on entry to DONE, out_state byte (r + 4c) = work byte (r + 4*((c+r)%4)), i.e. ShiftRows is applied.
  - Not defined: out_state = work register, SubBytes only.
  - Latency and handshake SHALL be identical in both builds.

Verification
REQ-026 Vector, both builds, LANES=4: in_state = 193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid rises 4 edges after acceptance.
  - Without macro: out_state = d42711aee0bf98f1b8b45de51e415230.
  - With macro: out_state = d4bf5d30e0b452aeb84111f11e2798e5.
REQ-027 Uniform inputs: in_state = all 00 -> out_state = all 63; all 52 -> all 00; all ff -> all 16 (both builds).
REQ-028 Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_valid and out_state remain stable; out_ready = 1 -> handshake, then in_ready = 1 on the next cycle.
REQ-029 Busy input: toggle in_valid with a different in_state during PROCESS -> no second capture; the result is still that of the first state.
REQ-030 Mid-operation reset: pulse rst after 2 PROCESS edges -> all outputs 0 immediately; the next input completes correctly after the full latency.
REQ-031 Sweep LANES in {1, 2, 4, 8, 16} with vector REQ-026 -> same result, with latency 16/LANES edges.
